median_window_sorter: RTL and testbench



---
 rtl/median_window_sorter.sv | 123 ++++++++++++
 tb/tb_median_window_sorter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/median_window_sorter.sv
// 3x3 median stage: loads nine pixels, sorts them with nine odd-even transposition passes, then presents the median.
// Define MEDIAN_MINMAX_EN to also expose the window min/max ports.
module median_window_sorter #(
  parameter int PIXEL_WIDTH = 8,
  parameter int X_LAST      = 237,
  parameter int Y_LAST      = 177
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PIXEL_WIDTH-1:0] pixelIn,
  input  logic                   pixelValid,
  output logic                   pixelReady,
  output logic [PIXEL_WIDTH-1:0] medianOut,
  output logic                   medianValid,
  input  logic                   medianReady,
  output logic [7:0]             xOut,
  output logic [7:0]             yOut,
`ifdef MEDIAN_MINMAX_EN
  output logic [PIXEL_WIDTH-1:0] minOut,
  output logic [PIXEL_WIDTH-1:0] maxOut,
`endif
  output logic                   frameDone
);

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  state_t                 r_state, w_next;
  logic [3:0]             r_idx, r_pass;
  logic [PIXEL_WIDTH-1:0] r_win [9];
  logic [PIXEL_WIDTH-1:0] w_sorted [9];
  logic [7:0]             r_x, r_y;
  logic                   r_done;
  logic                   w_x_last, w_y_last;

  assign w_x_last = (r_x == 8'(X_LAST));
  assign w_y_last = (r_y == 8'(Y_LAST));

  // Even passes pair (0,1)..(6,7), odd passes (1,2)..(7,8); pairs never overlap.
  always_comb begin
    for (int k = 0; k < 9; k++) w_sorted[k] = r_win[k];
    for (int k = 0; k < 8; k++) begin
      if ((k % 2) == int'(r_pass[0]) && r_win[k] > r_win[k+1]) begin
        w_sorted[k]   = r_win[k+1];
        w_sorted[k+1] = r_win[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LOAD;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (start) w_next = LOAD;
    else begin
      case (r_state)
        LOAD:    if (pixelValid && r_idx == 4'd8) w_next = SORT;
        SORT:    if (r_pass == 4'd8) w_next = OUT;
        OUT:     if (medianReady) w_next = LOAD;
        default: w_next = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx  <= '0;
      r_pass <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_done <= 1'b0;
      for (int k = 0; k < 9; k++) r_win[k] <= '0;
    end else if (start) begin
      // A pixel presented alongside start is dropped along with the partial window.
      r_idx  <= '0;
      r_pass <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        LOAD: if (pixelValid) begin
          r_win[r_idx] <= pixelIn;
          r_idx        <= (r_idx == 4'd8) ? 4'd0 : r_idx + 4'd1;
        end
        SORT: begin
          for (int k = 0; k < 9; k++) r_win[k] <= w_sorted[k];
          r_pass <= (r_pass == 4'd8) ? 4'd0 : r_pass + 4'd1;
        end
        OUT: if (medianReady) begin
          if (w_x_last) begin
            r_x <= '0;
            if (w_y_last) begin
              r_y    <= '0;
              r_done <= 1'b1;
            end else begin
              r_y <= r_y + 8'd1;
            end
          end else begin
            r_x <= r_x + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pixelReady  = (r_state == LOAD);
  assign medianValid = (r_state == OUT);
  assign medianOut   = r_win[4];
  assign xOut        = r_x;
  assign yOut        = r_y;
  assign frameDone   = r_done;
`ifdef MEDIAN_MINMAX_EN
  assign minOut      = r_win[0];
  assign maxOut      = r_win[8];
`endif

endmodule

// File: tb/tb_median_window_sorter.sv
// Bench for median_window_sorter: directed windows checked by literals plus a per-cycle reference model.
// A reduced window grid keeps the full-frame sweep short.
module tb_median_window_sorter;
  localparam int PW = 8;
  localparam int XL = 5;
  localparam int YL = 3;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [PW-1:0] pixelIn = '0;
  logic          pixelValid = 1'b0, medianReady = 1'b0;
  logic          pixelReady, medianValid, frameDone;
  logic [PW-1:0] medianOut;
  logic [7:0]    xOut, yOut;
`ifdef MEDIAN_MINMAX_EN
  logic [PW-1:0] minOut, maxOut;
`endif

  median_window_sorter #(.PIXEL_WIDTH(PW), .X_LAST(XL), .Y_LAST(YL)) dut (
    .clk(clk), .reset(reset), .start(start), .pixelIn(pixelIn), .pixelValid(pixelValid),
    .pixelReady(pixelReady), .medianOut(medianOut), .medianValid(medianValid),
    .medianReady(medianReady), .xOut(xOut), .yOut(yOut),
`ifdef MEDIAN_MINMAX_EN
    .minOut(minOut), .maxOut(maxOut),
`endif
    .frameDone(frameDone));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, ndone = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects accepted pixels, sorts a copy, tracks latency and coordinates.
  logic [PW-1:0] m_buf [9];
  logic [PW-1:0] m_med, m_min, m_max;
  int            m_cnt, m_lat;
  logic          m_vld, m_done;
  logic [7:0]    m_x, m_y;

  task automatic model_clear();
    m_cnt = 0; m_lat = 0; m_vld = 1'b0; m_x = 0; m_y = 0; m_done = 1'b0;
  endtask

  task automatic model_sort();
    logic [PW-1:0] s [9];
    logic [PW-1:0] t;
    for (int i = 0; i < 9; i++) s[i] = m_buf[i];
    for (int i = 1; i < 9; i++)
      for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
        t = s[j]; s[j] = s[j-1]; s[j-1] = t;
      end
    m_med = s[4]; m_min = s[0]; m_max = s[8];
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_clear();
    else if (start) model_clear();
    else begin
      m_done = 1'b0;
      if (m_vld) begin
        if (medianReady) begin
          m_vld = 1'b0;
          if (m_x == XL) begin
            m_x = 0;
            if (m_y == YL) begin m_y = 0; m_done = 1'b1; end
            else m_y = m_y + 1;
          end else m_x = m_x + 1;
        end
      end else if (m_lat > 0) begin
        m_lat--;
        if (m_lat == 0) m_vld = 1'b1;
      end else if (pixelValid) begin
        m_buf[m_cnt] = pixelIn;
        m_cnt++;
        if (m_cnt == 9) begin model_sort(); m_cnt = 0; m_lat = 9; end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("m_pixelReady", pixelReady, (!m_vld && m_lat == 0));
      chk("m_medianValid", medianValid, m_vld);
      chk("m_frameDone", frameDone, m_done);
      if (m_vld) begin
        chk("m_medianOut", medianOut, m_med);
        chk("m_xOut", xOut, m_x);
        chk("m_yOut", yOut, m_y);
`ifdef MEDIAN_MINMAX_EN
        chk("m_minOut", minOut, m_min);
        chk("m_maxOut", maxOut, m_max);
`endif
      end
    end
  end

  always @(posedge clk) if (frameDone) ndone++;

  task automatic send_px(input logic [PW-1:0] v);
    pixelValid = 1'b1; pixelIn = v;
    @(posedge clk); #1;
    pixelValid = 1'b0;
  endtask

  // v[8] is sent first, so a concatenation lists pixels in load order.
  task automatic load9(input logic [8:0][PW-1:0] v, input int gap_after4);
    for (int k = 8; k >= 0; k--) begin
      send_px(v[k]);
      if (k == 4) repeat (gap_after4) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!medianValid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("valid_timeout", medianValid, 1);
  endtask

  task automatic handshake();
    medianReady = 1'b1;
    @(posedge clk); #1;
    medianReady = 1'b0;
  endtask

  int lat, base;
  logic [8:0][PW-1:0] rv;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_pixelReady", pixelReady, 1);
    chk("rst_medianValid", medianValid, 0);
    chk("rst_medianOut", medianOut, 0);
    chk("rst_xy", {xOut, yOut}, 0);
    chk("rst_frameDone", frameDone, 0);

    load9({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 0);
    wait_valid(lat);
    chk("t1_latency", lat, 9);
    chk("t1_median", medianOut, 5);
    chk("t1_xy", {xOut, yOut}, 0);
`ifdef MEDIAN_MINMAX_EN
    chk("t1_min", minOut, 1);
    chk("t1_max", maxOut, 9);
`endif
    handshake();
    chk("t1_x_after", xOut, 1);

    load9({8'd200, 8'd200, 8'd200, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd17}, 0);
    wait_valid(lat);
    pixelValid = 1'b1; pixelIn = 8'd77;
    repeat (5) begin
      @(posedge clk); #1;
      chk("t2_hold_median", medianOut, 200);
      chk("t2_hold_ready", pixelReady, 0);
      chk("t2_hold_valid", medianValid, 1);
    end
    pixelValid = 1'b0;
    handshake();
    chk("t2_pixelReady", pixelReady, 1);
    chk("t2_x_after", xOut, 2);

    load9({8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd0, 8'd0, 8'd0, 8'd0} , 0);
    wait_valid(lat);
    handshake();
    for (int k = 0; k < 5; k++) send_px(8'(100 + k));
    start = 1'b1; pixelValid = 1'b1; pixelIn = 8'd250;
    @(posedge clk); #1;
    start = 1'b0; pixelValid = 1'b0;
    load9({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, 0);
    wait_valid(lat);
    chk("t3_median", medianOut, 5);
    chk("t3_xy", {xOut, yOut}, 0);
    handshake();

    load9({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, 3);
    wait_valid(lat);
    chk("t4_latency", lat, 9);
    chk("t4_median", medianOut, 5);
    handshake();

    load9({8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5}, 0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("t5_pixelReady", pixelReady, 1);
    chk("t5_medianValid", medianValid, 0);
    chk("t5_medianOut", medianOut, 0);
    chk("t5_xy", {xOut, yOut}, 0);
    @(posedge clk); #1 reset = 1'b0;
    load9({9{8'd42}}, 0);
    wait_valid(lat);
    chk("t5_median", medianOut, 42);
    handshake();

    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    base = ndone;
    for (int w = 0; w < (XL + 1) * (YL + 1); w++) begin
      for (int k = 0; k < 9; k++) rv[k] = 8'($urandom_range(0, 255));
      load9(rv, 0);
      wait_valid(lat);
      handshake();
      if (w == XL) chk("t6_row_wrap", {xOut, yOut}, {8'd0, 8'd1});
      if (w == (XL + 1) * (YL + 1) - 1) begin
        chk("t6_frameDone", frameDone, 1);
        chk("t6_frame_xy", {xOut, yOut}, 0);
        @(posedge clk); #1;
        chk("t6_frameDone_drop", frameDone, 0);
      end
    end
    chk("t6_frameDone_count", ndone - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
